// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer and its helpers.
package pll_seq_pkg;

  // Sequencer states. The encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_state_e;

  // Default cycle counts for the 12 MHz reference clock.
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 12;      // 1 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 120000;  // 10 ms
  localparam int DEF_LOCK_STABLE_CYCLES  = 1200;    // 100 us
  localparam int DEF_RELEASE_HOLD_CYCLES = 16;
  localparam int DEF_MAX_RETRIES         = 3;

  // Ceiling log2, clamped to at least 1 so it can always size a vector.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res < 1) res = 1;
    return res;
  endfunction

  // Largest of four cycle parameters; sizes the shared state counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level into the i_clk domain.
// Clears to 0 on a synchronous active-high reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the sampled level through the synchroniser chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the video/SDRAM PLL from the free-running reference clock:
// drives the PLL reset, qualifies lock, holds the system reset until lock
// has been stable, retries on timeout or lock loss, and flags a sticky fault
// after repeated consecutive timeouts. All outputs are registered and are
// decoded from the next state so they change on the same edge as the state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int RELEASE_HOLD_CYCLES = DEF_RELEASE_HOLD_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                                refclk,
  input  logic                                rst,
  input  logic                                pll_locked,
  output logic                                pll_rst,
  output logic                                sys_rst,
  output logic                                ready,
  output logic                                lock_lost,
  output logic                                fault,
  output logic [clog2(MAX_RETRIES+1)-1:0]     retry_count,
  output pll_state_e                          dbg_state
);

  localparam int RC_W  = clog2(MAX_RETRIES + 1);
  localparam int CNT_W = clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES, RELEASE_HOLD_CYCLES));

  // Terminal counter values: each timed state ends when the counter hits these.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RELEASE_HOLD_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_LIMIT     = RC_W'(MAX_RETRIES);

  pll_state_e       r_state;
  pll_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RC_W-1:0]  r_retry_count;
  logic [RC_W-1:0]  w_retry_next;
  logic             w_locked_s;
  logic             w_lock_lost;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_lock_lost;
  logic             r_fault;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // State register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= PLL_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, retry bookkeeping and lock-loss detection.
  always_comb begin
    w_next_state = r_state;
    w_retry_next = r_retry_count;
    w_lock_lost  = 1'b0;
    case (r_state)
      PLL_RST: begin
        // Lock seen here is ignored; the PLL reset always runs its full length.
        if (r_cnt == PLL_RST_LAST) w_next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next_state = STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_retry_next = r_retry_count + 1'b1;
          w_next_state = (w_retry_next == RC_LIMIT) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        // A single low cycle restarts both the stability count and timeout window.
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (!w_locked_s) begin
          w_next_state = PLL_RST;
        end else if (r_cnt == HOLD_LAST) begin
          w_next_state = RUN;
          w_retry_next = '0;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next_state = PLL_RST;
          w_lock_lost  = 1'b1;
        end
      end
      FAULT: begin
        w_next_state = FAULT;
      end
      default: begin
        w_next_state = PLL_RST;
      end
    endcase
  end

  // Shared state timer: cleared on every transition, frozen in untimed states.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if (r_state != RUN && r_state != FAULT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_fault       <= 1'b0;
      r_retry_count <= '0;
    end else begin
      r_pll_rst     <= (w_next_state == PLL_RST) || (w_next_state == FAULT);
      r_sys_rst     <= (w_next_state != RUN);
      r_ready       <= (w_next_state == RUN);
      r_lock_lost   <= w_lock_lost;
      r_fault       <= (w_next_state == FAULT);
      r_retry_count <= w_retry_next;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign fault       = r_fault;
  assign retry_count = r_retry_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with short cycle parameters. Expected output
// vectors {pll_rst, sys_rst, ready, lock_lost, fault, retry_count} are queued
// against absolute refclk edge numbers and compared on the following falling edge.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int W = 7;

  // Expected vectors, in bit order {pll_rst, sys_rst, ready, lock_lost, fault, rc[1:0]}.
  localparam logic [W-1:0] V_RESET    = 7'b1100000;
  localparam logic [W-1:0] V_WAIT_0   = 7'b0100000;
  localparam logic [W-1:0] V_RUN      = 7'b0010000;
  localparam logic [W-1:0] V_LOSS     = 7'b1101000;
  localparam logic [W-1:0] V_PRST_1   = 7'b1100001;
  localparam logic [W-1:0] V_WAIT_1   = 7'b0100001;
  localparam logic [W-1:0] V_FAULT    = 7'b1100110;

  // Clock and reset.
  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [1:0] retry_count;
  pll_state_e dbg_state;

  always #5 refclk = ~refclk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  pll_reset_sequencer #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (3),
    .LOCK_TIMEOUT_CYCLES (50),
    .LOCK_STABLE_CYCLES  (8),
    .RELEASE_HOLD_CYCLES (4),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .fault       (fault),
    .retry_count (retry_count),
    .dbg_state   (dbg_state)
  );

  wire [W-1:0] obs = {pll_rst, sys_rst, ready, lock_lost, fault, retry_count};

  // Scoreboard.
  logic [W-1:0] exp_q[$];
  int           at_q[$];
  string        tag_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input logic [W-1:0] v, input string tag);
    at_q.push_back(c);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Compare every queued expectation whose edge has been reached.
  always @(negedge refclk) begin
    while (at_q.size() > 0 && at_q[0] <= cyc) begin
      logic [W-1:0] e;
      string        t;
      void'(at_q.pop_front());
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_vec(t, {25'd0, obs}, {25'd0, e});
    end
  end

  // Driver tasks.
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  // One-edge synchronous reset; r returns the edge that applies it.
  task automatic apply_reset(input string tag, output int r);
    @(negedge refclk);
    rst        = 1'b1;
    pll_locked = 1'b0;
    r          = cyc + 1;
    expect_at(r, V_RESET, tag);
    @(negedge refclk);
    rst = 1'b0;
  endtask

  // Hard time limit so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int d;
    int l;

    // 1: clean lock 10 cycles after reset release.
    apply_reset("s1_reset", r);
    expect_at(r + 2,  V_RESET,  "s1_pll_rst_held");
    expect_at(r + 3,  V_WAIT_0, "s1_pll_rst_released");
    expect_at(r + 24, V_WAIT_0, "s1_hold_last");
    expect_at(r + 25, V_RUN,    "s1_run");
    wait_until(r + 10);
    pll_locked = 1'b1;
    wait_until(r + 25);

    // 4: lock loss in RUN after a random dwell, then relock (lock seen in PLL_RST).
    d = r + 25 + $urandom_range(2, 20);
    expect_at(d + 2,  V_RUN,    "s4_run_before_loss");
    expect_at(d + 3,  V_LOSS,   "s4_lock_lost_pulse");
    expect_at(d + 4,  V_RESET,  "s4_pulse_one_cycle");
    expect_at(d + 18, V_WAIT_0, "s4_relock_hold");
    expect_at(d + 19, V_RUN,    "s4_relock_run");
    wait_until(d);
    pll_locked = 1'b0;
    wait_until(d + 4);
    pll_locked = 1'b1;
    wait_until(d + 22);

    // 5a + 2: reset while in RUN, then a one-cycle glitch during STABLE.
    apply_reset("s5_reset_in_run", r);
    expect_at(r + 19, V_WAIT_0, "s2_no_early_release");
    expect_at(r + 24, V_WAIT_0, "s2_hold_last");
    expect_at(r + 25, V_RUN,    "s2_run_after_glitch");
    wait_until(r + 4);
    pll_locked = 1'b1;
    wait_until(r + 9);
    pll_locked = 1'b0;
    wait_until(r + 10);
    pll_locked = 1'b1;
    wait_until(r + 27);

    // 3 + 5b: no lock at all, two timeouts to FAULT, then reset out of FAULT.
    apply_reset("s3_reset", r);
    expect_at(r + 52,  V_WAIT_0, "s3_before_timeout1");
    expect_at(r + 53,  V_PRST_1, "s3_timeout1");
    expect_at(r + 55,  V_PRST_1, "s3_retry_pll_rst");
    expect_at(r + 56,  V_WAIT_1, "s3_retry_wait");
    expect_at(r + 105, V_WAIT_1, "s3_before_timeout2");
    expect_at(r + 106, V_FAULT,  "s3_fault");
    expect_at(r + 150, V_FAULT,  "s3_fault_sticky");
    wait_until(r + 150);
    apply_reset("s5_reset_in_fault", r);

    // 6: one timeout, then lock at a random point in the second window.
    expect_at(r + 53, V_PRST_1, "s6_timeout1");
    l = r + 56 + $urandom_range(0, 20);
    expect_at(l + 8,  V_WAIT_1, "s6_stable_keeps_rc");
    expect_at(l + 14, V_WAIT_1, "s6_hold_keeps_rc");
    expect_at(l + 15, V_RUN,    "s6_run_clears_rc");
    wait_until(l);
    pll_locked = 1'b1;
    wait_until(l + 17);

    check_vec("scoreboard_drained", at_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the video/SDRAM clock PLL (28 MHz pixel, 280 MHz TMDS, 168 MHz SDRAM plus shifted copy) from the free-running 12 MHz reference clock.
- Drives the PLL reset.
- Synchronises and qualifies the PLL locked flag.
- Holds the system reset until lock has been stable.
- Re-initialises the PLL on lock loss or lock timeout, and flags a fault after repeated failures.
- Sits directly upstream of the PLL reset input and downstream of its locked output; its sys_rst feeds the per-domain reset synchronisers of the HDMI and SDRAM blocks.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchroniser (≥2)
PLL_RST_CYCLES, 12, refclk cycles pll_rst is held after reset exit or on retry (1 µs at 12 MHz)
LOCK_TIMEOUT_CYCLES, 120000, max cycles in WAIT_LOCK before retry (10 ms)
LOCK_STABLE_CYCLES, 1200, consecutive synchronised-locked cycles required (100 µs)
RELEASE_HOLD_CYCLES, 16, extra cycles sys_rst is held after lock is qualified
MAX_RETRIES, 3, consecutive timeouts before FAULT (≥1)

Ports:
refclk  in  1  12 MHz reference clock, free-running, not PLL-derived
rst  in  1  synchronous reset, active-high
pll_locked  in  1  PLL locked flag, asynchronous to refclk
pll_rst  out  1  PLL reset, active-high
sys_rst  out  1  downstream system reset, active-high
ready  out  1  high exactly when sys_rst low
lock_lost  out  1  one-cycle pulse on loss of lock while running
fault  out  1  sticky; PLL failed MAX_RETRIES consecutive times
retry_count  out  clog2(MAX_RETRIES+1)  consecutive timeout count

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports refclk and rst). Everything else is sampled on the refclk rising edge, and all outputs are registered.
- Reset values: state=PLL_RST, counter=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, fault=0, retry_count=0. The synchroniser flops clear to 0.
- locked_s is the output of the SYNC_STAGES-flop synchroniser. It rises SYNC_STAGES edges after the first edge that samples pll_locked=1.
- A single counter is cleared on every state transition.
- PLL_RST:
  - pll_rst=1, sys_rst=1.
  - After PLL_RST_CYCLES cycles in state, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else, when counter reaches LOCK_TIMEOUT_CYCLES-1, increment retry_count. Go to FAULT if the new value equals MAX_RETRIES, otherwise go to PLL_RST.
- STABLE:
  - If locked_s=0 on any cycle, return to WAIT_LOCK. The timeout window restarts.
  - After LOCK_STABLE_CYCLES cycles with locked_s=1, go to HOLD.
- HOLD:
  - sys_rst=1.
  - If locked_s=0, go to PLL_RST. No lock_lost pulse, retry_count unchanged.
  - After RELEASE_HOLD_CYCLES cycles, go to RUN and clear retry_count.
- RUN:
  - sys_rst=0, ready=1.
  - On the first cycle locked_s=0: on the next edge, state=PLL_RST, sys_rst=1, ready=0, pll_rst=1, and lock_lost=1 for exactly one cycle.
- FAULT:
  - pll_rst=1, sys_rst=1, fault=1.
  - Exited only by rst.
- Latency: number refclk edges from 1, where edge 1 is the first edge that samples pll_locked=1. sys_rst falls at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+RELEASE_HOLD_CYCLES. This assumes pll_locked stays high and the block is already in WAIT_LOCK.
- pll_locked high during PLL_RST is ignored; PLL_RST always runs its full count.
- rst asserted in any state, including RUN or FAULT, restores the reset values on the next edge.
- Counter width: clog2 of the largest cycle parameter. The counter never wraps because every state terminates at or before its limit.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN, FAULT}
  - clog2 function
  - default cycle constants for the 12 MHz refclk
- One sub-module: bit_synchronizer (SYNC_STAGES-deep, synchronous active-high reset to 0), reused by the HDMI and SDRAM domain reset synchronisers.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=3, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8, RELEASE_HOLD_CYCLES=4, MAX_RETRIES=2.
1. Reset released, pll_locked rises 10 cycles later and stays high -> pll_rst low after 3 cycles; sys_rst falls at edge 15 counting from the first edge sampling locked=1; ready=1; retry_count=0.
2. pll_locked glitches low for 1 cycle during STABLE -> state returns to WAIT_LOCK, stability count restarts, sys_rst falls 15 edges after the final rise.
3. pll_locked never asserts -> after 3+50 cycles retry_count=1 and pll_rst pulses 3 cycles; after the second timeout fault=1, pll_rst=1, sys_rst=1, held until rst.
4. In RUN, pll_locked drops -> next edge sys_rst=1, ready=0, pll_rst=1, lock_lost=1 for one cycle; re-lock returns to RUN with retry_count=0.
5. rst asserted while in RUN and while in FAULT -> next edge all outputs at reset values, fault cleared.
6. One timeout, then lock succeeds -> retry_count=1 through STABLE/HOLD, cleared to 0 on entry to RUN.
